// File: rtl/spi_slave_pkg.sv
// ----------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the SPI frame receiver: FSM state encoding, default
// header/word lengths, field widths, status bit positions and the error word
// that the control stage returns through rdata.
// ----------------------------------------------------------------------------
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int HDR_BITS_DEF  = 24;
    localparam int WORD_BITS_DEF = 16;
    localparam int STATUS_W      = 4;
    localparam int ADDR_W        = 20;
    localparam int WORD_W        = 16;

    // Status bit positions: WR=1 write frame, BURST=1 multi-word, TGT target select
    localparam int ST_WR    = 2;
    localparam int ST_BURST = 1;
    localparam int ST_TGT   = 0;

    localparam logic [WORD_W-1:0] ERR_WORD = 16'h4552;

    // Bit-counter width able to index the longer of header and word
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// ----------------------------------------------------------------------------
// spi_frame_rx_if
// Control-stage side of the SPI frame receiver.
//   rdata/err          : control stage -> receiver (read word, error pulse)
//   address_ready, data_ready, miso_start : single-clk pulses from receiver
//   status/addr/wdata  : registered frame fields from receiver
//   frame_abort        : only present when SPI_FRAME_ABORT_EN is defined
// Modports: slave = receiver, master = control stage.
// ----------------------------------------------------------------------------
interface spi_frame_rx_if;
    import spi_slave_pkg::*;

    logic [WORD_W-1:0]   rdata;
    logic                err;
    logic                address_ready;
    logic                data_ready;
    logic                miso_start;
    logic [STATUS_W-1:0] status;
    logic [ADDR_W-1:0]   addr;
    logic [WORD_W-1:0]   wdata;
`ifdef SPI_FRAME_ABORT_EN
    logic                frame_abort;
`endif

    modport slave (
        input  rdata, err,
`ifdef SPI_FRAME_ABORT_EN
        output frame_abort,
`endif
        output address_ready, data_ready, miso_start, status, addr, wdata
    );

    modport master (
        output rdata, err,
`ifdef SPI_FRAME_ABORT_EN
        input  frame_abort,
`endif
        input  address_ready, data_ready, miso_start, status, addr, wdata
    );

endinterface

// File: rtl/spi_sync_edge.sv
// ----------------------------------------------------------------------------
// spi_sync_edge
// Synchronizes one asynchronous pin into the clk domain and flags its edges.
//   clk, reset : system clock, async active-high reset
//   din        : raw asynchronous pin
//   dout       : synchronized level
//   rise, fall : single-clk edge flags of dout
// RST_VAL sets the idle level the chain holds during reset.
// ----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        // Shift din in at bit 0; the cast drops the oldest sample
        sync_d = SYNC_STAGES'({sync_q, din});
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// ----------------------------------------------------------------------------
// spi_frame_rx
// SPI mode-0 slave frame receiver: header (status + address) followed by one
// data word, or a burst of words while status[BURST]=1. Read frames
// (status[WR]=0) return rdata on miso, MSB first.
//   clk, reset          : system clock, async active-high reset
//   sclk, mosi, cs_n_pad: raw SPI pins (asynchronous to clk)
//   cs_n                : synchronized chip select
//   miso, miso_oe       : serial read data and its output enable
//   bus (slave)         : control-stage pulses, fields and rdata/err
// Optional feature macro: SPI_FRAME_ABORT_EN adds bus.frame_abort.
// ----------------------------------------------------------------------------
module spi_frame_rx
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HDR_BITS    = HDR_BITS_DEF,
    parameter int WORD_BITS   = WORD_BITS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sclk,
    input  logic         mosi,
    input  logic         cs_n_pad,
    output logic         cs_n,
    output logic         miso,
    output logic         miso_oe,
    spi_frame_rx_if.slave bus
);

    localparam int CNT_W   = cnt_width(HDR_BITS, WORD_BITS);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    logic sclk_rise, sclk_fall, mosi_s, cs_n_s, cs_rise, cs_fall;
    logic sclk_lvl_unused, mosi_rise_unused, mosi_fall_unused, unused_err;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs_n_pad),
        .dout(cs_n_s), .rise(cs_rise), .fall(cs_fall));

    // err is informational; error data arrives through rdata
    assign unused_err = bus.err;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [HDR_BITS-2:0]   hdr_sh_q, hdr_sh_d;
    logic [WORD_BITS-2:0]  word_sh_q, word_sh_d;
    logic [WORD_W-1:0]     miso_sh_q, miso_sh_d;
    logic                  load_pend_q, load_pend_d;
    logic [STATUS_W-1:0]   status_q, status_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  address_ready_q, address_ready_d;
    logic                  data_ready_q, data_ready_d;
    logic                  miso_start_q, miso_start_d;
    logic [FLUSH_W-1:0]    flush_q, flush_d;
    logic                  armed_q, armed_d;
`ifdef SPI_FRAME_ABORT_EN
    logic                  frame_abort_q, frame_abort_d;
`endif

    logic [HDR_BITS-1:0]   hdr_full;
    logic [WORD_BITS-1:0]  word_full;
    logic                  flush_done;

    // Shifter contents including the bit arriving on this rise
    assign hdr_full   = {hdr_sh_q, mosi_s};
    assign word_full  = {word_sh_q, mosi_s};
    assign flush_done = (flush_q == FLUSH_W'(SYNC_STAGES));

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        hdr_sh_d        = hdr_sh_q;
        word_sh_d       = word_sh_q;
        miso_sh_d       = miso_sh_q;
        load_pend_d     = load_pend_q;
        status_d        = status_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        address_ready_d = 1'b0;
        data_ready_d    = 1'b0;
        miso_start_d    = 1'b0;
`ifdef SPI_FRAME_ABORT_EN
        frame_abort_d   = 1'b0;
`endif
        // After reset the synchronizer holds cs_n=1 regardless of the pin, so a
        // frame may only start once the flushed chain has shown cs_n high.
        flush_d = flush_done ? flush_q : flush_q + FLUSH_W'(1);
        armed_d = armed_q | (flush_done & cs_n_s);

        case (state_q)
            ST_IDLE: begin
                if (armed_q && cs_fall) begin
                    state_d   = ST_HDR;
                    bit_cnt_d = '0;
                end
            end
            ST_HDR: begin
                if (sclk_rise) begin
                    hdr_sh_d = hdr_full[HDR_BITS-2:0];
                    if (bit_cnt_q == CNT_W'(HDR_BITS - 1)) begin
                        bit_cnt_d       = '0;
                        status_d        = hdr_full[HDR_BITS-1 -: STATUS_W];
                        addr_d          = hdr_full[ADDR_W-1:0];
                        address_ready_d = 1'b1;
                        load_pend_d     = ~hdr_full[HDR_BITS-STATUS_W+ST_WR];
                        state_d         = ST_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (sclk_rise) begin
                    word_sh_d = word_full[WORD_BITS-2:0];
                    if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
                        bit_cnt_d    = '0;
                        data_ready_d = 1'b1;
                        if (status_q[ST_WR])
                            wdata_d = WORD_W'(word_full);
                        if (status_q[ST_BURST])
                            load_pend_d = ~status_q[ST_WR];
                        else
                            state_d = ST_DRAIN;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                // Rise and fall are never detected in the same clk
                if (sclk_fall) begin
                    if (load_pend_q) begin
                        miso_sh_d    = bus.rdata;
                        miso_start_d = 1'b1;
                        load_pend_d  = 1'b0;
                    end else begin
                        miso_sh_d = {miso_sh_q[WORD_W-2:0], 1'b0};
                    end
                end
            end
            ST_DRAIN: begin
                if (sclk_fall)
                    miso_sh_d = {miso_sh_q[WORD_W-2:0], 1'b0};
            end
        endcase

        // Chip-select release ends the frame from any state, discarding any
        // partial word and suppressing pulses.
        if (cs_rise) begin
`ifdef SPI_FRAME_ABORT_EN
            frame_abort_d   = ((state_q == ST_HDR) || (state_q == ST_DATA)) &&
                              (bit_cnt_q != '0);
`endif
            state_d         = ST_IDLE;
            bit_cnt_d       = '0;
            load_pend_d     = 1'b0;
            miso_sh_d       = '0;
            address_ready_d = 1'b0;
            data_ready_d    = 1'b0;
            miso_start_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            hdr_sh_q        <= '0;
            word_sh_q       <= '0;
            miso_sh_q       <= '0;
            load_pend_q     <= 1'b0;
            status_q        <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            address_ready_q <= 1'b0;
            data_ready_q    <= 1'b0;
            miso_start_q    <= 1'b0;
            flush_q         <= '0;
            armed_q         <= 1'b0;
`ifdef SPI_FRAME_ABORT_EN
            frame_abort_q   <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            hdr_sh_q        <= hdr_sh_d;
            word_sh_q       <= word_sh_d;
            miso_sh_q       <= miso_sh_d;
            load_pend_q     <= load_pend_d;
            status_q        <= status_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            address_ready_q <= address_ready_d;
            data_ready_q    <= data_ready_d;
            miso_start_q    <= miso_start_d;
            flush_q         <= flush_d;
            armed_q         <= armed_d;
`ifdef SPI_FRAME_ABORT_EN
            frame_abort_q   <= frame_abort_d;
`endif
        end
    end

    assign cs_n    = cs_n_s;
    assign miso    = miso_sh_q[WORD_W-1];
    assign miso_oe = ~cs_n_s & ~status_q[ST_WR] &
                     ((state_q == ST_DATA) || (state_q == ST_DRAIN));

    assign bus.address_ready = address_ready_q;
    assign bus.data_ready    = data_ready_q;
    assign bus.miso_start    = miso_start_q;
    assign bus.status        = status_q;
    assign bus.addr          = addr_q;
    assign bus.wdata         = wdata_q;
`ifdef SPI_FRAME_ABORT_EN
    assign bus.frame_abort   = frame_abort_q;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_spi_frame_rx
// Directed bench for spi_frame_rx: an SPI mode-0 host drives frames on the
// raw pins, a negedge monitor counts output pulses and records wdata.
// Honors SPI_FRAME_ABORT_EN for the frame_abort output.
// ----------------------------------------------------------------------------
module tb_spi_frame_rx;
    import spi_slave_pkg::*;

    localparam int HALF = 10;   // clk cycles per sclk half period (20x)

    logic clk = 1'b0;
    logic reset, sclk, mosi, cs_n_pad;
    logic cs_n, miso, miso_oe;

    spi_frame_rx_if bus();

    spi_frame_rx dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n_pad(cs_n_pad),
        .cs_n(cs_n), .miso(miso), .miso_oe(miso_oe), .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- output monitor ----------------
    int n_ar = 0, n_dr = 0, n_ms = 0, n_ab = 0, n_overlap = 0;
    logic [15:0] wq[$];
    int          ms_at_dr[$];

    always @(negedge clk) begin
        if (bus.address_ready) n_ar <= n_ar + 1;
        if (bus.data_ready) begin
            n_dr <= n_dr + 1;
            wq.push_back(bus.wdata);
            ms_at_dr.push_back(n_ms);
        end
        if (bus.miso_start) n_ms <= n_ms + 1;
        if ((32'(bus.address_ready) + 32'(bus.data_ready) + 32'(bus.miso_start)) > 1)
            n_overlap <= n_overlap + 1;
`ifdef SPI_FRAME_ABORT_EN
        if (bus.frame_abort) n_ab <= n_ab + 1;
`endif
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int ar0, dr0, ms0, ab0, q0;

    task automatic snap();
        ar0 = n_ar; dr0 = n_dr; ms0 = n_ms; ab0 = n_ab; q0 = wq.size();
    endtask

    // ---------------- SPI host ----------------
    task automatic cs_low();
        cs_n_pad = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs_n_pad = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    // Sends n bits of v MSB first; captures miso just before each rise
    task automatic send_bits(input logic [31:0] v, input int n, output logic [31:0] cap);
        cap = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            repeat (HALF) @(negedge clk);
            cap  = {cap[30:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    logic [31:0] cap;

    initial begin
        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n_pad = 1'b1;
        bus.rdata = '0; bus.err = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_cs_n",   32'(cs_n), 32'd1);
        check_eq("rst_pins",   32'({miso, miso_oe}), 32'd0);
        check_eq("rst_pulses", 32'({bus.address_ready, bus.data_ready, bus.miso_start}), 32'd0);
        check_eq("rst_fields", 32'({bus.status, bus.addr}), 32'd0);
        check_eq("rst_wdata",  32'(bus.wdata), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Write single, then extra bits that DRAIN must ignore
        snap();
        cs_low();
        send_bits(32'h412344, 24, cap);
        check_eq("ws_addr",   32'(bus.addr), 32'h12344);
        check_eq("ws_status", 32'(bus.status), 32'h4);
        send_bits(32'hBEEF, 16, cap);
        check_eq("ws_miso", cap, 32'd0);
        send_bits(32'h1234, 16, cap);
        check_eq("ws_oe", 32'(miso_oe), 32'd0);
        cs_high();
        check_eq("ws_ar_cnt",  32'(n_ar - ar0), 32'd1);
        check_eq("ws_dr_cnt",  32'(n_dr - dr0), 32'd1);
        check_eq("ws_wq",      32'(wq[q0]), 32'hBEEF);
        check_eq("ws_wdata",   32'(bus.wdata), 32'hBEEF);
        check_eq("ws_ms_cnt",  32'(n_ms - ms0), 32'd0);

        // Write burst of three words
        snap();
        cs_low();
        send_bits(32'h6ABCDE, 24, cap);
        for (int w = 1; w <= 3; w++) send_bits(32'(w), 16, cap);
        cs_high();
        check_eq("wb_status", 32'(bus.status), 32'h6);
        check_eq("wb_dr_cnt", 32'(n_dr - dr0), 32'd3);
        for (int i = 0; i < 3; i++) check_eq("wb_word", 32'(wq[q0+i]), 32'(i + 1));
        check_eq("wb_ms_cnt", 32'(n_ms - ms0), 32'd0);

        // Read single; err toggling must have no effect
        bus.rdata = 16'hA5C3;
        bus.err   = 1'b1;
        snap();
        cs_low();
        send_bits(32'h000010, 24, cap);
        bus.err = 1'b0;
        send_bits(32'h0, 16, cap);
        check_eq("rs_word", cap, 32'hA5C3);
        check_eq("rs_oe_on", 32'(miso_oe), 32'd1);
        cs_high();
        check_eq("rs_oe_off", 32'(miso_oe), 32'd0);
        check_eq("rs_addr",   32'(bus.addr), 32'h10);
        check_eq("rs_ms_cnt", 32'(n_ms - ms0), 32'd1);
        check_eq("rs_dr_cnt", 32'(n_dr - dr0), 32'd1);
        check_eq("rs_wdata_kept", 32'(bus.wdata), 32'h3);

        // Read burst returning the error word
        bus.rdata = ERR_WORD;
        snap();
        cs_low();
        send_bits(32'h200400, 24, cap);
        for (int w = 0; w < 3; w++) begin
            send_bits(32'h0, 16, cap);
            check_eq("rb_word", cap, 32'(ERR_WORD));
        end
        check_eq("rb_oe_on", 32'(miso_oe), 32'd1);
        cs_high();
        check_eq("rb_dr_cnt", 32'(n_dr - dr0), 32'd3);
        check_eq("rb_ms_per_word", 32'(ms_at_dr[q0+2] - ms0), 32'd3);

        // Abort after 10 header bits, then a clean frame
        snap();
        cs_low();
        send_bits(32'h3FF, 10, cap);
        cs_high();
        check_eq("ab_ar_cnt", 32'(n_ar - ar0), 32'd0);
        check_eq("ab_oe",     32'(miso_oe), 32'd0);
`ifdef SPI_FRAME_ABORT_EN
        check_eq("ab_pulse",  32'(n_ab - ab0), 32'd1);
`endif
        snap();
        cs_low();
        send_bits(32'h4ABCDE, 24, cap);
        send_bits(32'h5A5A, 16, cap);
        cs_high();
        check_eq("ab2_addr",   32'(bus.addr), 32'hABCDE);
        check_eq("ab2_status", 32'(bus.status), 32'h4);
        check_eq("ab2_wdata",  32'(bus.wdata), 32'h5A5A);
        check_eq("ab2_ar_cnt", 32'(n_ar - ar0), 32'd1);

        // Reset at bit 8 of a data word
        cs_low();
        send_bits(32'h400055, 24, cap);
        send_bits(32'hC3, 8, cap);
        reset = 1'b1;
        #1;
        check_eq("mr_cs_n",   32'(cs_n), 32'd1);
        check_eq("mr_fields", 32'({bus.status, bus.addr}), 32'd0);
        check_eq("mr_wdata",  32'(bus.wdata), 32'd0);
        check_eq("mr_pins",   32'({miso, miso_oe, bus.address_ready, bus.data_ready, bus.miso_start}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        snap();
        send_bits(32'h3C, 8, cap);     // rest of the abandoned frame
        cs_high();
        check_eq("mr_no_ar", 32'(n_ar - ar0), 32'd0);
        check_eq("mr_no_dr", 32'(n_dr - dr0), 32'd0);
        cs_low();
        send_bits(32'h400777, 24, cap);
        send_bits(32'h0F0F, 16, cap);
        cs_high();
        check_eq("mr2_addr",  32'(bus.addr), 32'h777);
        check_eq("mr2_wdata", 32'(bus.wdata), 32'h0F0F);

        check_eq("no_pulse_overlap", 32'(n_overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
